// File: rtl/mode_clock_gen.sv
// Switch-selected divided clock with a run-time divisor table, debounced mode select
// and glitch-free mode changes applied only at half-period boundaries.
module mode_clock_gen #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 10,
  parameter logic [(2**SEL_W)*CNT_W-1:0] DIV_TABLE =
    {CNT_W'(100), CNT_W'(250), CNT_W'(500), CNT_W'(0)},
  parameter int DEBOUNCE = 4
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] SW,
  output logic             mode_clock,
  output logic             rise_tick,
  output logic [SEL_W-1:0] mode,
  output logic             pending
);

  localparam int STAB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] div_of(input logic [SEL_W-1:0] m);
    return DIV_TABLE[int'(m)*CNT_W +: CNT_W];
  endfunction

  logic [SEL_W-1:0]  s1_q, sw_s_q;
  logic [SEL_W-1:0]  cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  mode_q, mode_d;
  logic [SEL_W-1:0]  target_q, target_d;
  logic              mc_q, mc_d;
  logic              rise_q, rise_d;
  logic              pending_q, pending_d;

  logic              accept;
  logic              boundary;
  logic [SEL_W-1:0]  req;

  // Debouncer: a select is accepted only after DEBOUNCE stable samples.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cand_d = cand_q;
    stab_d = stab_q;
    if (sw_s_q != cand_q) begin
      cand_d = sw_s_q;
      stab_d = '0;
    end else if (stab_q != STAB_W'(DEBOUNCE)) begin
      stab_d = stab_q + STAB_W'(1);
    end
  end

  assign accept   = (stab_q == STAB_W'(DEBOUNCE));
  assign boundary = (cnt_q == div_of(mode_q) - CNT_W'(1));
  // Latest accepted select wins over a stored target.
  assign req      = accept ? cand_q : target_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    target_d = target_q;
    mc_d     = mc_q;

    unique case (state_q)
      IDLE: begin
        mc_d  = 1'b0;
        cnt_d = '0;
        if (accept) begin
          mode_d = cand_q;
          if (div_of(cand_q) != '0) state_d = RUN;
        end
      end

      RUN, PEND: begin
        if (boundary) begin
          cnt_d = '0;
          mc_d  = ~mc_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == RUN) begin
          if (accept && (cand_q != mode_q)) begin
            target_d = cand_q;
            state_d  = PEND;
          end
        end else begin
          target_d = req;
          if (req == mode_q) begin
            state_d = RUN;
          end else if (boundary) begin
            if (div_of(req) != '0) begin
              mode_d  = req;
              state_d = RUN;
            end else if (mc_q) begin
              // A stop mode is entered only on the falling toggle.
              mode_d  = req;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mc_d    = 1'b0;
      end
    endcase

    rise_d    = mc_d & ~mc_q;
    pending_d = (state_d == PEND);
  end

  always_ff @(posedge SCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (RST) begin
      s1_q      <= '0;
      sw_s_q    <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      target_q  <= '0;
      mc_q      <= 1'b0;
      rise_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      s1_q      <= SW;
      sw_s_q    <= s1_q;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      mc_q      <= mc_d;
      rise_q    <= rise_d;
      pending_q <= pending_d;
    end
  end

  assign mode_clock = mc_q;
  assign rise_tick  = rise_q;
  assign mode       = mode_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_mode_clock_gen.sv
// Randomised scoreboard bench for mode_clock_gen: two instances (default table and a
// table with a divide-by-1 mode) share SW/RST and are checked cycle by cycle.
module tb_mode_clock_gen;

  localparam int SEL_W    = 2;
  localparam int CNT_W    = 10;
  localparam int DEBOUNCE = 4;
  localparam int MAXH     = 40000;
  localparam logic [4*CNT_W-1:0] TABLE_A = {10'd100, 10'd250, 10'd500, 10'd0};
  localparam logic [4*CNT_W-1:0] TABLE_B = {10'd100, 10'd250, 10'd1,   10'd0};

  typedef struct packed {
    logic       mc;
    logic       rise;
    logic [1:0] mode;
    logic       pend;
  } obs_t;

  logic       SCLK = 1'b0;
  logic       RST  = 1'b1;
  logic [1:0] SW   = 2'd0;

  logic       mc_a, rise_a, pend_a;
  logic [1:0] mode_a;
  logic       mc_b, rise_b, pend_b;
  logic [1:0] mode_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 SCLK = ~SCLK;

  mode_clock_gen #(.SEL_W(SEL_W), .CNT_W(CNT_W), .DIV_TABLE(TABLE_A), .DEBOUNCE(DEBOUNCE)) dut_a (
    .SCLK(SCLK), .RST(RST), .SW(SW),
    .mode_clock(mc_a), .rise_tick(rise_a), .mode(mode_a), .pending(pend_a)
  );

  mode_clock_gen #(.SEL_W(SEL_W), .CNT_W(CNT_W), .DIV_TABLE(TABLE_B), .DEBOUNCE(DEBOUNCE)) dut_b (
    .SCLK(SCLK), .RST(RST), .SW(SW),
    .mode_clock(mc_b), .rise_tick(rise_b), .mode(mode_b), .pending(pend_b)
  );

  // Reference model: half-periods as countdowns, acceptance as a window over SW history.
  int         div_tab [2][4] = '{'{0, 500, 250, 100}, '{0, 1, 250, 100}};
  logic [1:0] samp    [MAXH];
  int         edge_n   = 0;
  int         last_rst = 0;
  bit         m_mc      [2];
  bit         m_pend    [2];
  bit         m_stopped [2];
  logic [1:0] m_mode    [2];
  logic [1:0] m_target  [2];
  int         m_rem     [2];
  obs_t       exp_a[$];
  obs_t       exp_b[$];

  task automatic model_step(input int i, input bit rst, input bit acc, input logic [1:0] cand);
    bit   old_mc;
    bit   bnd;
    obs_t o;
    old_mc = m_mc[i];
    if (rst) begin
      m_mc[i] = 0; m_pend[i] = 0; m_stopped[i] = 1;
      m_mode[i] = 2'd0; m_target[i] = 2'd0; m_rem[i] = 0;
    end else if (m_stopped[i]) begin
      m_mc[i] = 0;
      if (acc) begin
        m_mode[i] = cand;
        if (div_tab[i][cand] != 0) begin
          m_stopped[i] = 0;
          m_rem[i]     = div_tab[i][cand];
        end
      end
    end else begin
      m_rem[i] = m_rem[i] - 1;
      bnd = (m_rem[i] == 0);
      if (bnd) begin
        m_mc[i]  = ~m_mc[i];
        m_rem[i] = div_tab[i][m_mode[i]];
      end
      if (!m_pend[i]) begin
        if (acc && cand != m_mode[i]) begin
          m_pend[i]   = 1;
          m_target[i] = cand;
        end
      end else begin
        if (acc) m_target[i] = cand;
        if (m_target[i] == m_mode[i]) begin
          m_pend[i] = 0;
        end else if (bnd) begin
          if (div_tab[i][m_target[i]] != 0) begin
            m_mode[i] = m_target[i];
            m_pend[i] = 0;
            m_rem[i]  = div_tab[i][m_target[i]];
          end else if (!m_mc[i]) begin
            m_mode[i]    = m_target[i];
            m_pend[i]    = 0;
            m_stopped[i] = 1;
          end
        end
      end
    end
    o.mc   = m_mc[i];
    o.rise = m_mc[i] & ~old_mc;
    o.mode = m_mode[i];
    o.pend = m_pend[i];
    if (i == 0) exp_a.push_back(o);
    else        exp_b.push_back(o);
  endtask

  initial begin
    for (int j = 0; j < MAXH; j++) samp[j] = 2'd0;
    forever begin
      bit         rst_now;
      bit         acc;
      logic [1:0] cand;
      int         n;
      @(posedge SCLK);
      rst_now = RST;
      n = edge_n + 8;
      if (n < MAXH) begin
        if (rst_now) begin
          samp[n] = 2'd0; samp[n-1] = 2'd0; samp[n-2] = 2'd0;
          last_rst = edge_n;
        end else begin
          samp[n] = SW;
        end
        cand = samp[n-3];
        acc  = 0;
        if (!rst_now && edge_n >= last_rst + DEBOUNCE + 1) begin
          acc = 1;
          for (int j = n - 3 - DEBOUNCE; j <= n - 3; j++)
            if (samp[j] != cand) acc = 0;
        end
        model_step(0, rst_now, acc, cand);
        model_step(1, rst_now, acc, cand);
      end
      edge_n++;
    end
  end

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got mc=%b rise=%b mode=%0d pend=%b, expected mc=%b rise=%b mode=%0d pend=%b",
               name, edge_n, act.mc, act.rise, act.mode, act.pend,
               exp.mc, exp.rise, exp.mode, exp.pend);
    end
  endtask

  // Monitor: the outputs are presented every cycle; compare away from the active edge.
  initial begin
    forever begin
      obs_t e;
      @(negedge SCLK);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("dut_a", {mc_a, rise_a, mode_a, pend_a}, e);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("dut_b", {mc_b, rise_b, mode_b, pend_b}, e);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s wait budget expired at edge=%0d", name, edge_n);
  endtask

  initial begin
    bit found;
    SW  = 2'd0;
    RST = 1'b1;
    cycles(3);
    RST = 1'b0;
    cycles(20);

    // Run mode 1 for a couple of periods.
    SW = 2'd1;
    cycles(2300);

    // Short glitches to mode 3 must never be accepted.
    repeat (4) begin
      SW = 2'd3;
      cycles($urandom_range(1, DEBOUNCE));
      SW = 2'd1;
      cycles($urandom_range(40, 150));
    end
    cycles(600);

    // 1 -> 2 -> 1 inside one half-period: request then cancel.
    found = 0;
    for (int k = 0; k < 1200 && !found; k++) begin
      if (m_mode[0] == 2'd1 && !m_pend[0] && m_rem[0] > 100) found = 1;
      else cycles(1);
    end
    if (!found) timeout("wait_cancel_window");
    SW = 2'd2;
    cycles(DEBOUNCE + 6);
    SW = 2'd1;
    cycles(1200);

    // 1 -> 3 while running, then 3 -> 2.
    SW = 2'd3;
    cycles(1500);
    SW = 2'd2;
    cycles(1200);

    // 2 -> 0 while the clock is low: must finish a full high phase, then stop.
    found = 0;
    for (int k = 0; k < 1200 && !found; k++) begin
      if (m_mode[0] == 2'd2 && !m_pend[0] && !m_mc[0] && m_rem[0] > 20) found = 1;
      else cycles(1);
    end
    if (!found) timeout("wait_low_phase");
    SW = 2'd0;
    cycles(900);

    // Random selects with random hold times, including sub-debounce ones.
    repeat (14) begin
      SW = 2'($urandom_range(0, 3));
      cycles($urandom_range(1, 700));
    end

    // Divide-by-1 mode on dut_b, then reset in mid-run.
    SW = 2'd1;
    cycles(200);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    cycles($urandom_range(30, 80));
    SW = 2'd3;
    cycles(150);
    RST = 1'b1;
    cycles(2);
    RST = 1'b0;
    cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
